// File: rtl/posit_pkg.sv
// Shared posit definitions for the arithmetic units (adder, multiplier,
// converters, encoder).
//   - posit_log2      : ceiling log2, used to derive the regime-count width Bs
//   - N_DEF / ES_DEF  : default posit width and exponent field width
//   - BS_DEF / SW_DEF : derived Bs and signed-scale width for the defaults
//   - posit_maxk      : largest regime magnitude that still fits (N-2)
//   - posit_maxpos / posit_minpos / posit_nar : bit patterns, LSB-aligned,
//     to be truncated to N bits by the user
package posit_pkg;

  function automatic int posit_log2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < v) r = i + 1;
    end
    return r;
  endfunction

  localparam int N_DEF  = 8;
  localparam int ES_DEF = 2;
  localparam int BS_DEF = posit_log2(N_DEF);
  localparam int SW_DEF = BS_DEF + ES_DEF + 2;

  function automatic int posit_maxk(input int n);
    return n - 2;
  endfunction

  localparam int MAXK_DEF = posit_maxk(N_DEF);

  // 0111...1
  function automatic logic [63:0] posit_maxpos(input int n);
    return (64'd1 << (n - 1)) - 64'd1;
  endfunction

  // 000...01
  function automatic logic [63:0] posit_minpos(input int n);
    return (n > 0) ? 64'd1 : 64'd0;
  endfunction

  // 100...0
  function automatic logic [63:0] posit_nar(input int n);
    return 64'd1 << (n - 1);
  endfunction

endpackage

// File: rtl/posit_round_rne.sv
// Round-to-nearest-even for a truncated posit body (everything below the
// sign bit).
// Ports:
//   body_i   [N-2:0]  truncated body (regime, exponent, fraction)
//   guard_i           first bit below the truncation point
//   sticky_i          OR of every bit below the guard
//   body_o   [N-2:0]  rounded body
// An all-ones body is never incremented (it would wrap into NaR), and a body
// that ends up all zeros is lifted to minpos so finite values never become 0.
module posit_round_rne #(
  parameter int N = 8
) (
  input  logic [N-2:0] body_i,
  input  logic         guard_i,
  input  logic         sticky_i,
  output logic [N-2:0] body_o
);

  localparam int BW = N - 1;

  function automatic logic [BW-1:0] rne(input logic [BW-1:0] b,
                                        input logic          g,
                                        input logic          s);
    logic          inc;
    logic [BW-1:0] sum;
    inc = g & (s | b[0]);
    // A carry out of the fraction ripples into exponent and regime, which is
    // exactly the next representable posit.
    sum = b + BW'(inc);
    if (&b) return b;
    if (sum == '0) return BW'(1);
    return sum;
  endfunction

  assign body_o = rne(body_i, guard_i, sticky_i);

endmodule

// File: rtl/posit_encoder.sv
// Pipelined posit packer: turns a decoded value (sign, signed power-of-two
// scale, fraction below the hidden 1, zero/NaR flags) into a rounded N-bit
// posit. One operation per cycle; start sampled at edge t gives done and the
// result after edge t+3.
// Ports:
//   clk, rst_n         rising-edge clock, asynchronous active-low reset
//   start              input fields valid this cycle
//   in_sign            sign of the value
//   in_scale [SW-1:0]  signed two's-complement scale (regime*2^es + exponent)
//   in_frac  [N-1:0]   fraction bits below the hidden 1, MSB weight 2^-1
//   in_zero, in_inf    value is exact zero / NaR (NaR wins if both)
//   out      [N-1:0]   encoded posit
//   inf, zero          out is NaR / out is zero
//   done               one-cycle pulse, out/inf/zero valid
module posit_encoder
  import posit_pkg::*;
#(
  parameter  int N  = N_DEF,
  parameter  int es = ES_DEF,
  localparam int Bs = posit_log2(N),
  localparam int SW = Bs + es + 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic                 in_sign,
  input  logic signed [SW-1:0] in_scale,
  input  logic        [N-1:0]  in_frac,
  input  logic                 in_zero,
  input  logic                 in_inf,
  output logic        [N-1:0]  out,
  output logic                 inf,
  output logic                 zero,
  output logic                 done
);

  localparam int BW   = N - 1;
  // Longest regime is N bits (k = N-2 gives N-1 ones and a terminator), so
  // a lead bit + exponent + fraction shifted by up to N-1 fits in L bits
  // without losing anything off the right end.
  localparam int L    = 2 * N + es;
  localparam int MAXK = posit_maxk(N);

  localparam logic signed [SW-1:0] SAT_POS = SW'(MAXK << es);
  localparam logic signed [SW-1:0] SAT_NEG = -SAT_POS;
  localparam logic signed [SW-1:0] ONE_S   = SW'(1);

  localparam logic [N-1:0]  NAR_PAT     = N'(posit_nar(N));
  localparam logic [BW-1:0] MAXPOS_BODY = BW'(posit_maxpos(N));
  localparam logic [BW-1:0] MINPOS_BODY = BW'(posit_minpos(N));

  // Out-of-range scales bypass rounding and land on the extreme finite
  // values; packed as {body, guard, sticky}.
  function automatic logic [BW+1:0] saturate(input logic            hi,
                                             input logic            lo,
                                             input logic [BW+1:0]   raw);
    if (hi) return {MAXPOS_BODY, 2'b00};
    if (lo) return {MINPOS_BODY, 2'b00};
    return raw;
  endfunction

  // Control (reset) and data (no reset) registers
  logic                 vld_p0, vld_p1, vld_p2;

  logic                 sign_p0, zero_p0, inf_p0;
  logic signed [SW-1:0] scale_p0;
  logic        [N-1:0]  frac_p0;

  logic                 sign_p1, nar_p1, zro_p1, sathi_p1, satlo_p1;
  logic signed [SW-1:0] k_p1;
  logic        [es-1:0] e_p1;
  logic        [N-1:0]  frac_p1;

  logic                 sign_p2, nar_p2, zro_p2;
  logic        [BW-1:0] body_p2;
  logic                 guard_p2, sticky_p2;

  logic        [N-1:0]  out_q, out_d;
  logic                 inf_q, inf_d, zero_q, zero_d, done_q;

  logic        [SW-1:0] rlen;
  logic        [L-1:0]  str;
  logic        [BW-1:0] body_d;
  logic                 guard_d, sticky_d;
  logic        [BW-1:0] rbody;
  logic        [N-1:0]  mag;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p0 <= 1'b0;
      vld_p1 <= 1'b0;
      vld_p2 <= 1'b0;
      out_q  <= '0;
      inf_q  <= 1'b0;
      zero_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      vld_p0 <= start;
      vld_p1 <= vld_p0;
      vld_p2 <= vld_p1;
      done_q <= vld_p2;
      if (vld_p2) begin
        out_q  <= out_d;
        inf_q  <= inf_d;
        zero_q <= zero_d;
      end
    end
  end

  // ---- p0: capture input fields
  always_ff @(posedge clk) begin
    if (start) begin
      sign_p0  <= in_sign;
      scale_p0 <= in_scale;
      frac_p0  <= in_frac;
      zero_p0  <= in_zero;
      inf_p0   <= in_inf;
    end
  end

  // ---- p1: split scale into regime k and exponent e, classify
  always_ff @(posedge clk) begin
    if (vld_p0) begin
      sign_p1  <= sign_p0;
      k_p1     <= scale_p0 >>> es;
      e_p1     <= scale_p0[es-1:0];
      frac_p1  <= frac_p0;
      nar_p1   <= inf_p0;
      zro_p1   <= zero_p0 & ~inf_p0;
      sathi_p1 <= scale_p0 > SAT_POS;
      satlo_p1 <= scale_p0 < SAT_NEG;
    end
  end

  // ---- p2: build regime|exponent|fraction string, truncate, guard/sticky
  // For k >= 0 the run is k+1 ones: shift in a 0 terminator and OR ones into
  // the vacated top bits. For k < 0 the run is -k zeros: shift a 1
  // terminator right and let zeros fill from the top.
  always_comb begin
    rlen = '0;
    str  = '0;
    if (k_p1[SW-1]) begin
      rlen = -k_p1;
      str  = {1'b1, e_p1, frac_p1, {BW{1'b0}}} >> rlen;
    end else begin
      rlen = k_p1 + ONE_S;
      str  = ({1'b0, e_p1, frac_p1, {BW{1'b0}}} >> rlen) | ~({L{1'b1}} >> rlen);
    end
    {body_d, guard_d, sticky_d} = saturate(sathi_p1, satlo_p1,
                                           {str[L-1 -: BW], str[L-1-BW], |str[L-2-BW:0]});
  end

  always_ff @(posedge clk) begin
    if (vld_p1) begin
      sign_p2   <= sign_p1;
      nar_p2    <= nar_p1;
      zro_p2    <= zro_p1;
      body_p2   <= body_d;
      guard_p2  <= guard_d;
      sticky_p2 <= sticky_d;
    end
  end

  // ---- output: round, apply sign, override specials
  posit_round_rne #(.N(N)) u_round (
    .body_i   (body_p2),
    .guard_i  (guard_p2),
    .sticky_i (sticky_p2),
    .body_o   (rbody)
  );

  assign mag = {1'b0, rbody};

  always_comb begin
    out_d  = sign_p2 ? -mag : mag;
    inf_d  = 1'b0;
    zero_d = 1'b0;
    if (nar_p2) begin
      out_d = NAR_PAT;
      inf_d = 1'b1;
    end else if (zro_p2) begin
      out_d  = '0;
      zero_d = 1'b1;
    end
  end

  assign out  = out_q;
  assign inf  = inf_q;
  assign zero = zero_q;
  assign done = done_q;

endmodule

// File: tb/tb_posit_encoder.sv
module tb_posit_encoder;
  import posit_pkg::*;

  logic                     clk;
  logic                     rst_n;
  logic                     start;
  logic                     in_sign;
  logic signed [SW_DEF-1:0] in_scale;
  logic        [7:0]        in_frac;
  logic                     in_zero;
  logic                     in_inf;
  logic        [7:0]        out;
  logic                     inf;
  logic                     zero;
  logic                     done;

  int n_pass  = 0;
  int n_total = 0;

  posit_encoder #(.N(8), .es(2)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .in_sign  (in_sign),
    .in_scale (in_scale),
    .in_frac  (in_frac),
    .in_zero  (in_zero),
    .in_inf   (in_inf),
    .out      (out),
    .inf      (inf),
    .zero     (zero),
    .done     (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time %0t exceeded bound", $time);
    $fatal(1, "watchdog");
  end

  task automatic set_inputs(input logic s, input int sc, input logic [7:0] f,
                            input logic z, input logic i);
    in_sign  = s;
    in_scale = sc[SW_DEF-1:0];
    in_frac  = f;
    in_zero  = z;
    in_inf   = i;
  endtask

  // Issue one start pulse, then watch a bounded window for done.
  task automatic run_op(input logic s, input int sc, input logic [7:0] f,
                        input logic z, input logic i,
                        output logic [7:0] o, output logic oi, output logic oz,
                        output int lat, output int ndone);
    @(negedge clk);
    set_inputs(s, sc, f, z, i);
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    lat   = -1;
    ndone = 0;
    o     = '0;
    oi    = 1'b0;
    oz    = 1'b0;
    for (int c = 0; c <= 6; c++) begin
      if (c > 0) begin
        @(posedge clk);
        #1;
      end
      if (done) begin
        ndone++;
        if (lat < 0) begin
          lat = c;
          o   = out;
          oi  = inf;
          oz  = zero;
        end
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b1;
    start = 1'b0;
    set_inputs(1'b0, 0, 8'h00, 1'b0, 1'b0);
    #1 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    n_total++; if (out !== 8'h00) $display("FAIL reset out: got %h expected 00", out); else n_pass++;
    n_total++; if (inf !== 1'b0) $display("FAIL reset inf: got %b expected 0", inf); else n_pass++;
    n_total++; if (zero !== 1'b0) $display("FAIL reset zero: got %b expected 0", zero); else n_pass++;
    n_total++; if (done !== 1'b0) $display("FAIL reset done: got %b expected 0", done); else n_pass++;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_unit();
    int         sc_t [5] = '{0, 1, 4, -1, 0};
    logic       sg_t [5] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    logic [7:0] ex_t [5] = '{8'h40, 8'h48, 8'h60, 8'h38, 8'hC0};
    logic [7:0] o;
    logic       oi, oz;
    int         lat, nd;
    for (int v = 0; v < 5; v++) begin
      run_op(sg_t[v], sc_t[v], 8'h00, 1'b0, 1'b0, o, oi, oz, lat, nd);
      n_total++; if (o !== ex_t[v]) $display("FAIL unit[%0d] out: got %h expected %h", v, o, ex_t[v]); else n_pass++;
      n_total++; if (lat !== 3) $display("FAIL unit[%0d] latency: got %0d expected 3", v, lat); else n_pass++;
      n_total++; if (nd !== 1) $display("FAIL unit[%0d] done count: got %0d expected 1", v, nd); else n_pass++;
      n_total++; if ({oi, oz} !== 2'b00) $display("FAIL unit[%0d] inf/zero: got %b expected 00", v, {oi, oz}); else n_pass++;
    end
  endtask

  task automatic test_rounding();
    logic [7:0] fr_t [4] = '{8'h80, 8'h18, 8'h10, 8'h30};
    logic [7:0] ex_t [4] = '{8'h44, 8'h41, 8'h40, 8'h42};
    logic [7:0] o;
    logic       oi, oz;
    int         lat, nd;
    for (int v = 0; v < 4; v++) begin
      run_op(1'b0, 0, fr_t[v], 1'b0, 1'b0, o, oi, oz, lat, nd);
      n_total++; if (o !== ex_t[v]) $display("FAIL round[%0d] frac=%h out: got %h expected %h", v, fr_t[v], o, ex_t[v]); else n_pass++;
      n_total++; if (lat !== 3) $display("FAIL round[%0d] latency: got %0d expected 3", v, lat); else n_pass++;
    end
  endtask

  task automatic test_saturation();
    int         sc_t [5] = '{30, -30, 24, 30, -24};
    logic [7:0] fr_t [5] = '{8'h00, 8'h00, 8'hFF, 8'h00, 8'h00};
    logic       sg_t [5] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    logic [7:0] ex_t [5] = '{8'h7F, 8'h01, 8'h7F, 8'h81, 8'h01};
    logic [7:0] o;
    logic       oi, oz;
    int         lat, nd;
    for (int v = 0; v < 5; v++) begin
      run_op(sg_t[v], sc_t[v], fr_t[v], 1'b0, 1'b0, o, oi, oz, lat, nd);
      n_total++; if (o !== ex_t[v]) $display("FAIL sat[%0d] scale=%0d out: got %h expected %h", v, sc_t[v], o, ex_t[v]); else n_pass++;
      n_total++; if ({oi, oz} !== 2'b00) $display("FAIL sat[%0d] inf/zero: got %b expected 00", v, {oi, oz}); else n_pass++;
    end
  endtask

  task automatic test_specials();
    logic       z_t  [3] = '{1'b1, 1'b0, 1'b1};
    logic       i_t  [3] = '{1'b0, 1'b1, 1'b1};
    logic [7:0] ex_t [3] = '{8'h00, 8'h80, 8'h80};
    logic [1:0] iz_t [3] = '{2'b01, 2'b10, 2'b10};
    logic [7:0] o;
    logic       oi, oz;
    int         lat, nd;
    for (int v = 0; v < 3; v++) begin
      run_op(1'b1, 5, 8'hA5, z_t[v], i_t[v], o, oi, oz, lat, nd);
      n_total++; if (o !== ex_t[v]) $display("FAIL special[%0d] out: got %h expected %h", v, o, ex_t[v]); else n_pass++;
      n_total++; if ({oi, oz} !== iz_t[v]) $display("FAIL special[%0d] inf/zero: got %b expected %b", v, {oi, oz}, iz_t[v]); else n_pass++;
      n_total++; if (lat !== 3) $display("FAIL special[%0d] latency: got %0d expected 3", v, lat); else n_pass++;
    end
  endtask

  task automatic test_back_to_back();
    int         sc_t [6] = '{0, 1, 4, -1, 0, 0};
    logic       z_t  [6] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    logic       i_t  [6] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    logic [7:0] ex_t [6] = '{8'h40, 8'h48, 8'h60, 8'h38, 8'h00, 8'h80};
    logic [1:0] iz_t [6] = '{2'b00, 2'b00, 2'b00, 2'b00, 2'b01, 2'b10};
    logic       exp_done;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      if (c < 6) begin
        set_inputs(1'b0, sc_t[c], 8'h00, z_t[c], i_t[c]);
        start = 1'b1;
      end else begin
        start = 1'b0;
      end
      @(posedge clk);
      #1;
      exp_done = (c >= 3) && (c <= 8);
      n_total++; if (done !== exp_done) $display("FAIL stream cycle %0d done: got %b expected %b", c, done, exp_done); else n_pass++;
      if (exp_done) begin
        n_total++; if (out !== ex_t[c-3]) $display("FAIL stream op %0d out: got %h expected %h", c - 3, out, ex_t[c-3]); else n_pass++;
        n_total++; if ({inf, zero} !== iz_t[c-3]) $display("FAIL stream op %0d inf/zero: got %b expected %b", c - 3, {inf, zero}, iz_t[c-3]); else n_pass++;
      end
    end
  endtask

  task automatic test_reset_midstream();
    logic [7:0] o;
    logic       oi, oz;
    int         lat, nd;
    @(negedge clk);
    set_inputs(1'b0, 4, 8'h00, 1'b0, 1'b0);
    start = 1'b1;
    @(negedge clk);
    set_inputs(1'b0, 1, 8'h00, 1'b0, 1'b0);
    @(posedge clk);
    #1;
    start = 1'b0;
    rst_n = 1'b0;
    #1;
    n_total++; if (done !== 1'b0) $display("FAIL midreset done: got %b expected 0", done); else n_pass++;
    n_total++; if (out !== 8'h00) $display("FAIL midreset out: got %h expected 00", out); else n_pass++;
    n_total++; if ({inf, zero} !== 2'b00) $display("FAIL midreset inf/zero: got %b expected 00", {inf, zero}); else n_pass++;
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    nd = 0;
    for (int c = 0; c < 6; c++) begin
      @(posedge clk);
      #1;
      if (done) nd++;
    end
    n_total++; if (nd !== 0) $display("FAIL midreset stale dones: got %0d expected 0", nd); else n_pass++;
    run_op(1'b0, 4, 8'h00, 1'b0, 1'b0, o, oi, oz, lat, nd);
    n_total++; if (o !== 8'h60) $display("FAIL postreset out: got %h expected 60", o); else n_pass++;
    n_total++; if (lat !== 3) $display("FAIL postreset latency: got %0d expected 3", lat); else n_pass++;
    n_total++; if (nd !== 1) $display("FAIL postreset done count: got %0d expected 1", nd); else n_pass++;
  endtask

  initial begin
    test_reset();
    test_unit();
    test_rounding();
    test_saturation();
    test_specials();
    test_back_to_back();
    test_reset_midstream();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/posit_encoder.md
Name: posit_encoder

Overview:
- Pipelined posit packer, the inverse of the unpack stage at the front of posit_adder.
- Takes a decoded value (sign, signed scale, fraction without the hidden bit, and zero/NaR flags) and returns a rounded N-bit posit.
- Sits at the output end of the posit arithmetic units and is reused by the multiplier and converters.
- Uses the same start/done, inf/zero convention as posit_adder.

Parameters:
- N, 8, posit width in bits.
- es, 2, exponent field width.
- Bs, log2(N), derived; not overridden.
- SW, Bs+es+2, width of the signed scale input.

Ports:
- clk  input  1  clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  input fields valid this cycle.
- in_sign  input  1  sign of the value.
- in_scale  input  SW  signed two's-complement power-of-two scale.
- in_frac  input  N  fraction bits below the hidden 1, MSB weight 2^-1.
- in_zero  input  1  value is exact zero.
- in_inf  input  1  value is NaR.
- out  output  N  encoded posit.
- inf  output  1  out is NaR (1000...0).
- zero  output  1  out is 0.
- done  output  1  one-cycle pulse; out/inf/zero valid.

Behaviour:
- Reset (async assert, sync release):
  - out=0, inf=0, zero=0, done=0.
  - All pipeline valid bits cleared; in-flight operations are discarded and produce no done.
- Fully pipelined, 3 register stages, one operation per cycle.
- Latency: start sampled high at edge t gives done=1 and valid results after edge t+3.
- Holding start high gives a done every cycle.
- start low gives no done; out/inf/zero hold their last values.
- Stage 1, register inputs:
  - k = in_scale >>> es (arithmetic); e = in_scale[es-1:0].
  - Special flags computed here; in_inf has priority over in_zero.
- Stage 1, saturation:
  - in_scale > (N-2)*2^es: force maxpos (0111...1); no rounding.
  - in_scale < -(N-2)*2^es: force minpos (000...01); no rounding.
  - Finite values never encode to 0 or NaR.
- Stage 2, build an unbounded body string:
  - Regime: k>=0 gives k+1 ones then a 0; k<0 gives -k zeros then a 1.
  - Then e (es bits), then in_frac.
  - Truncate to N-1 body bits.
  - Keep guard = next bit; sticky = OR of all remaining bits. This includes regime, exponent and fraction bits pushed off the end.
- Stage 3, round to nearest, ties to even:
  - Increment when guard & (sticky | lsb).
  - The carry propagates into the exponent/regime naturally.
  - An unrounded body of all ones is never incremented (maxpos clamp).
  - A truncated body of all zeros is forced to 1 (minpos).
- Stage 3, output:
  - out = in_sign ? two's complement of {0, body} : {0, body}.
  - Special outputs: NaR gives out=1000...0, inf=1, zero=0; zero gives out=0, zero=1, inf=0.
  - For special inputs, in_sign and in_frac are ignored.
- Simultaneous in_zero & in_inf: NaR.
- Reset asserted mid-stream: done low immediately; the first done after release is at least 3 edges after the first post-release start.

Decomposition:
- posit_pkg holds:
  - log2 function.
  - Defaults N=8, es=2.
  - Derived Bs and SW.
  - Constants MAXK = N-2, maxpos/minpos/NaR patterns as functions of N.
- One combinational sub-module, posit_round_rne: in body N-1 bits, guard, sticky; out rounded body. It handles the maxpos/minpos clamps and is shared with the multiplier.
- Regime construction stays inline.

Test Plan (N=8, es=2):
- Unit values, start pulses:
  - scale=0, frac=0x00, sign=0 -> out=0x40 three cycles later, done one cycle.
  - scale=1 -> 0x48; scale=4 -> 0x60; scale=-1 -> 0x38.
  - sign=1, scale=0 -> 0xC0.
- Fraction/rounding at scale=0:
  - frac=0x80 -> 0x44.
  - frac=0x18 -> 0x41 (round up).
  - frac=0x10 -> 0x40 (tie to even).
  - frac=0x30 -> 0x42 (tie, odd lsb).
- Saturation:
  - scale=30 -> 0x7F; scale=-30 -> 0x01.
  - scale=24, frac=0xFF -> 0x7F (no wrap to 0x80).
  - sign=1, scale=30 -> 0x81.
- Specials:
  - in_zero=1 -> out=0x00, zero=1.
  - in_inf=1 -> out=0x80, inf=1.
  - both set -> 0x80, inf=1, zero=0.
- Streaming: hold start high for 6 cycles with the scale=0,1,4,-1 and both specials vectors -> 6 consecutive dones in input order, each 3 cycles after its input.
- Reset: assert rst_n=0 with 2 ops in flight -> outputs 0 and done 0 immediately, no stale done after release.
